// File: rtl/rmt_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rmt_input_arbiter
// Purpose  : Packet-granular two-input AXI-Stream arbiter feeding the RMT
//            pipeline, with a registered output and per-port packet counters.
// Options  : define ARB_STRICT_PRIO_EN for strict port-0 priority
//            (round-robin when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module rmt_input_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              areset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    input  logic                              s0_axis_tlast,
    output logic                              s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    input  logic                              s1_axis_tlast,
    output logic                              s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [CNT_WIDTH-1:0]              pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]              pkt_cnt_1
);

    localparam int c_KEEP_WIDTH = C_S_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t                            r_state;
    logic                              r_last_grant;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    r_m_tdata;
    logic [c_KEEP_WIDTH-1:0]           r_m_tkeep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   r_m_tuser;
    logic                              r_m_tvalid;
    logic                              r_m_tlast;
    logic [CNT_WIDTH-1:0]              r_pkt_cnt_0;
    logic [CNT_WIDTH-1:0]              r_pkt_cnt_1;

    logic w_out_free;
    logic w_s0_ready;
    logic w_s1_ready;
    logic w_acc0;
    logic w_acc1;

    // Output register can take a beat when empty or draining this cycle.
    assign w_out_free = !r_m_tvalid || m_axis_tready;
    assign w_s0_ready = (r_state == ST_GRANT0) && w_out_free;
    assign w_s1_ready = (r_state == ST_GRANT1) && w_out_free;
    assign w_acc0     = s0_axis_tvalid && w_s0_ready;
    assign w_acc1     = s1_axis_tvalid && w_s1_ready;

    assign s0_axis_tready = w_s0_ready;
    assign s1_axis_tready = w_s1_ready;
    assign m_axis_tdata   = r_m_tdata;
    assign m_axis_tkeep   = r_m_tkeep;
    assign m_axis_tuser   = r_m_tuser;
    assign m_axis_tvalid  = r_m_tvalid;
    assign m_axis_tlast   = r_m_tlast;
    assign pkt_cnt_0      = r_pkt_cnt_0;
    assign pkt_cnt_1      = r_pkt_cnt_1;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_m_tdata    <= '0;
            r_m_tkeep    <= '0;
            r_m_tuser    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_pkt_cnt_0  <= '0;
            r_pkt_cnt_1  <= '0;
        end else begin
            if (w_acc0) begin
                r_m_tdata  <= s0_axis_tdata;
                r_m_tkeep  <= s0_axis_tkeep;
                r_m_tuser  <= s0_axis_tuser;
                r_m_tlast  <= s0_axis_tlast;
                r_m_tvalid <= 1'b1;
            end else if (w_acc1) begin
                r_m_tdata  <= s1_axis_tdata;
                r_m_tkeep  <= s1_axis_tkeep;
                r_m_tuser  <= s1_axis_tuser;
                r_m_tlast  <= s1_axis_tlast;
                r_m_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
`ifdef ARB_STRICT_PRIO_EN
                    if (s0_axis_tvalid) begin
                        r_state <= ST_GRANT0;
                        if (s1_axis_tvalid) begin
                            r_last_grant <= 1'b0;
                        end
                    end else if (s1_axis_tvalid) begin
                        r_state <= ST_GRANT1;
                    end
`else
                    // last_grant only moves on a genuine tie.
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        if (r_last_grant) begin
                            r_state      <= ST_GRANT0;
                            r_last_grant <= 1'b0;
                        end else begin
                            r_state      <= ST_GRANT1;
                            r_last_grant <= 1'b1;
                        end
                    end else if (s0_axis_tvalid) begin
                        r_state <= ST_GRANT0;
                    end else if (s1_axis_tvalid) begin
                        r_state <= ST_GRANT1;
                    end
`endif
                end
                ST_GRANT0: begin
                    if (w_acc0 && s0_axis_tlast) begin
                        r_state     <= ST_IDLE;
                        r_pkt_cnt_0 <= r_pkt_cnt_0 + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_GRANT1: begin
                    if (w_acc1 && s1_axis_tlast) begin
                        r_state     <= ST_IDLE;
                        r_pkt_cnt_1 <= r_pkt_cnt_1 + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rmt_input_arbiter.md
# rmt_input_arbiter

Packet-granular two-input AXI-Stream arbiter in front of `rmt_wrapper`. It merges a data-plane stream (port 0) and a second tenant or control-packet stream (port 1) into the single 512-bit RMT pipeline input. Packets are never interleaved, and tdata/tkeep/tuser/tlast pass through unmodified. The output is registered, and per-port packet counters are exposed for software.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 512, tdata width of both inputs and the output.
- `C_S_AXIS_TUSER_WIDTH`, 128, tuser width.
- `CNT_WIDTH`, 32, width of each packet counter.

Ports:
- `clk`  in  1  single clock for all logic.
- `areset`  in  1  asynchronous, active-high reset.
- `s0_axis_tdata/tkeep/tuser/tvalid/tlast`  in  512/64/128/1/1  port 0 slave stream.
- `s0_axis_tready`  out  1  port 0 ready.
- `s1_axis_tdata/tkeep/tuser/tvalid/tlast`  in  512/64/128/1/1  port 1 slave stream.
- `s1_axis_tready`  out  1  port 1 ready.
- `m_axis_tdata/tkeep/tuser/tvalid/tlast`  out  512/64/128/1/1  merged stream to `rmt_wrapper`.
- `m_axis_tready`  in  1  downstream ready.
- `pkt_cnt_0`, `pkt_cnt_1`  out  CNT_WIDTH  packets forwarded per port.

## Operation
- FSM states: IDLE, GRANT0, GRANT1. State and `last_grant` are registers; `last_grant` resets to 1 so port 0 wins the first tie.
- IDLE:
  - Only s0 valid → GRANT0.
  - Only s1 valid → GRANT1.
  - Both valid → grant the port not equal to `last_grant`, and set `last_grant` to the granted port.
  - Neither valid → stay in IDLE.
  - Both readies are 0 in IDLE.
- GRANTk:
  - `sk_axis_tready = !m_axis_tvalid || m_axis_tready`; the other port's tready is 0.
  - An accepted beat (`sk_tvalid && sk_tready`) loads the output register with that beat's tdata/tkeep/tuser/tlast and sets `m_axis_tvalid`.
  - An accepted beat with tlast=1 → IDLE, and `pkt_cnt_k` increments.
- Output register:
  - `m_axis_tvalid` clears when `m_axis_tready` is high and no new beat is loaded that cycle.
  - Once valid, output data stays stable until accepted, per AXIS rules.
- Counters increment by 1 per packet, wrap modulo 2^CNT_WIDTH, and are never cleared except by reset.
- A tlast on the very first beat (single-beat packet) is legal: the arbiter enters GRANTk, transfers one beat, and returns to IDLE.
- Upstream tvalid dropping mid-packet does not release the grant. The FSM waits in GRANTk indefinitely until tlast is transferred.

## Timing
- Reset (async assert, sync-safe deassert on `clk`):
  - state = IDLE, `last_grant` = 1.
  - `m_axis_tvalid` = 0; `m_axis_tdata/tkeep/tuser/tlast` = 0.
  - `s0/s1_axis_tready` = 0; `pkt_cnt_0/1` = 0.
- Reset mid-packet: the partial packet is dropped at the output and not counted. After reset the source must restart at a packet boundary; the arbiter does not track this.
- Arbitration latency: tvalid seen in IDLE at cycle N → GRANTk at N+1 → first beat accepted at N+1 if the output register is empty → `m_axis_tvalid` high at N+2.
- Each packet boundary costs exactly one IDLE bubble cycle on the input side.
- Steady-state throughput is one beat per cycle while `m_axis_tready` is 1.
- Backpressure: with `m_axis_tready` = 0 and the output register full, `sk_tready` = 0 in the same cycle (combinational from `m_axis_tready`).
- Simultaneous events:
  - In a single cycle, the final beat of port k can be accepted while the output register drains; both happen.
  - Counter increment coincides with the tlast acceptance edge.

## Configuration
- `ARB_STRICT_PRIO_EN`:
  - Defined: IDLE always grants port 0 when s0 is valid, so port 1 is served only when s0 is idle. `last_grant` is still updated but ignored.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold `areset` = 1 for 2 cycles with both inputs valid → all readies 0, `m_axis_tvalid` 0, counters 0; after release, port 0 is granted first.
- Single port: drive on s0 only a 2-beat packet (beat1 tkeep = 64'hffffffffffffffff, tuser = 128'h10042; beat2 tkeep = 64'h3, tlast = 1) with `m_axis_tready` = 1.
  - Output shows identical beats 2 cycles after first tvalid.
  - `pkt_cnt_0` = 1; `pkt_cnt_1` = 0.
- Contention: both ports present 3 two-beat packets continuously → output order is 0,1,0,1,0,1; packets are never interleaved; `pkt_cnt_0` = `pkt_cnt_1` = 3.
- Backpressure: toggle `m_axis_tready` 1,0,0,1 during a 3-beat s1 packet → no beat lost or duplicated; output data stays stable while tready is 0.
- Mid-packet stall: s0 drops tvalid for 5 cycles between beats while s1 is valid → s1 tready stays 0 until s0's tlast is transferred.
- `ARB_STRICT_PRIO_EN` defined: s0 and s1 continuously valid → only s0 packets forwarded; `pkt_cnt_1` stays 0.
